// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int MEM_AW = 14;
  localparam int MEM_DW = 32;
  localparam logic [3:0] WEB_READ = 4'b1111;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IM   = 2'd1,
    RESP_DM   = 2'd2
  } resp_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating loss counter. It tells a low-priority master when it has waited long
// enough to be forced through once.
module arb_starve_counter #(
  parameter int LIMIT = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  // Count lost cycles, saturate at the limit, and clear whenever the master wins or goes idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= {CNT_W{1'b0}};
    end else if (clr) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != LIM)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign at_limit = (count == LIM);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access.
// DM has priority, but IM is forced through once after losing STARVE_LIMIT cycles in a row.
// Read data comes back one cycle later and is steered to the port that issued the read.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [MEM_AW-1:0] im_addr,
  output logic              im_gnt,
  output logic              im_rvalid,
  output logic [MEM_DW-1:0] im_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_web,
  input  logic [MEM_AW-1:0] dm_addr,
  input  logic [MEM_DW-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [MEM_DW-1:0] dm_rdata,
  output logic              cpu_stall,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic [3:0]        mem_web,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_datain,
  input  logic [MEM_DW-1:0] mem_dataout
);

  resp_e             state;
  resp_e             state_next;
  logic              at_limit;
  logic              im_lose;
  logic [CNT_W-1:0]  starve_count;
  logic [MEM_DW-1:0] im_hold;
  logic [MEM_DW-1:0] dm_hold;

  assign im_lose = im_req & ~im_gnt;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (im_lose),
    .clr      (~im_lose),
    .count    (starve_count),
    .at_limit (at_limit)
  );

  // Grant: DM first unless IM has starved; nothing is granted while reset is held.
  always_comb begin
    im_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      im_gnt = 1'b0;
      dm_gnt = 1'b0;
    end else if (dm_req && !(im_req && at_limit)) begin
      dm_gnt = 1'b1;
    end else if (im_req) begin
      im_gnt = 1'b1;
    end else begin
      im_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  assign cpu_stall = rst & ((im_req & ~im_gnt) | (dm_req & ~dm_gnt));

  // SRAM port mux: the winner drives the macro, and fetches are always plain reads.
  always_comb begin
    mem_cs     = 1'b0;
    mem_web    = WEB_READ;
    mem_addr   = {MEM_AW{1'b0}};
    mem_datain = {MEM_DW{1'b0}};
    if (dm_gnt) begin
      mem_cs     = 1'b1;
      mem_web    = dm_web;
      mem_addr   = dm_addr;
      mem_datain = dm_wdata;
    end else if (im_gnt) begin
      mem_cs     = 1'b1;
      mem_web    = WEB_READ;
      mem_addr   = im_addr;
      mem_datain = {MEM_DW{1'b0}};
    end else begin
      mem_cs     = 1'b0;
      mem_web    = WEB_READ;
      mem_addr   = {MEM_AW{1'b0}};
      mem_datain = {MEM_DW{1'b0}};
    end
  end

  assign mem_oe = mem_cs;

  // Response state register: records which port owns next cycle's SRAM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESP_NONE;
    end else begin
      state <= state_next;
    end
  end

  // Response next-state: only reads produce a response, and stores complete silently.
  always_comb begin
    state_next = RESP_NONE;
    if (im_gnt) begin
      state_next = RESP_IM;
    end else if (dm_gnt && (dm_web == WEB_READ)) begin
      state_next = RESP_DM;
    end else begin
      state_next = RESP_NONE;
    end
  end

  // Response outputs: pass fresh data straight through, otherwise present the last value.
  always_comb begin
    im_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    im_rdata  = im_hold;
    dm_rdata  = dm_hold;
    case (state)
      RESP_IM: begin
        im_rvalid = 1'b1;
        im_rdata  = mem_dataout;
      end
      RESP_DM: begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_dataout;
      end
      default: begin
        im_rvalid = 1'b0;
        dm_rvalid = 1'b0;
      end
    endcase
  end

  // Hold registers keep each port's last read data stable between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_hold <= {MEM_DW{1'b0}};
      dm_hold <= {MEM_DW{1'b0}};
    end else begin
      im_hold <= (state == RESP_IM) ? mem_dataout : im_hold;
      dm_hold <= (state == RESP_DM) ? mem_dataout : dm_hold;
    end
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous SRAM (14-bit word address, 32-bit data, byte write enables) between the CPU instruction-fetch port and the data-memory port.
- Sits between the pipeline's IF/MEM stages and the unified memory macro.
- Uses fixed DM-over-IM priority with an IM anti-starvation counter, and drives a pipeline stall when either requester is not granted.
- Tracks the one-cycle read latency and routes returned data back to the requester that issued the read.

Parameters:
STARVE_LIMIT, 3, consecutive cycles IM may lose arbitration before it is forced to win once (legal range 1..15)
CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
im_req  in  1  fetch request (always a read)
im_addr  in  14  fetch word address
im_gnt  out  1  fetch accepted this cycle
im_rvalid  out  1  im_rdata carries fresh fetch data this cycle
im_rdata  out  32  fetch data (held between reads)
dm_req  in  1  data request
dm_web  in  4  active-low byte write enables; 4'b1111 = read
dm_addr  in  14  data word address
dm_wdata  in  32  store data, pre-aligned by the store path
dm_gnt  out  1  data access accepted this cycle
dm_rvalid  out  1  dm_rdata carries fresh load data this cycle
dm_rdata  out  32  load data (held between reads)
cpu_stall  out  1  (im_req & ~im_gnt) | (dm_req & ~dm_gnt)
mem_cs  out  1  SRAM chip select
mem_oe  out  1  SRAM output enable
mem_web  out  4  SRAM active-low byte write enables
mem_addr  out  14  SRAM word address
mem_datain  out  32  SRAM write data
mem_dataout  in  32  SRAM read data, valid the cycle after a read is issued

Behaviour:
- Reset (rst=0, asynchronous):
  - Response state = RESP_NONE; starvation counter = 0; im/dm hold registers = 0.
  - Outputs: gnt/rvalid = 0, cpu_stall = 0, mem_cs = 0, mem_oe = 0, mem_web = 4'b1111, mem_addr = 0, mem_datain = 0.
  - A read issued in the cycle before reset asserts never produces rvalid after reset releases.
- Arbitration (combinational, same cycle):
  - Only dm_req: DM granted.
  - Only im_req: IM granted.
  - Both: DM granted unless the counter equals STARVE_LIMIT; in that case IM is granted.
- Starvation counter, registered:
  - Increments (saturating at STARVE_LIMIT) on each cycle im_req=1 and im_gnt=0.
  - Clears to 0 on any im_gnt, and on any cycle im_req=0.
- SRAM drive:
  - Granted requester's address/web/data go to mem_*; mem_cs = mem_oe = 1.
  - IM grant always drives mem_web = 4'b1111 and mem_datain = 0.
  - No grant: mem_cs = 0, mem_web = 4'b1111, mem_addr/mem_datain = 0.
- Response FSM (registered), states RESP_NONE / RESP_IM / RESP_DM:
  - Next state RESP_IM if IM granted this cycle.
  - RESP_DM if DM granted with dm_web == 4'b1111.
  - Otherwise RESP_NONE; a DM write never produces rvalid.
- Read data return:
  - In RESP_IM: im_rvalid = 1, im_rdata = mem_dataout (combinational pass-through), and the IM hold register captures mem_dataout at the clock edge.
  - Outside RESP_IM: im_rdata = IM hold register.
  - DM side behaves identically with RESP_DM.
- Simultaneous events:
  - A new grant may be issued in the same cycle as a response; the SRAM is pipelined at one access per cycle.
  - Throughput is 1 access/cycle with zero bubbles.
- Requests are level-sensitive. A requester that is not granted must hold req and its address/data stable; the block does not latch losing requests.
- Partial writes: mem_web passes through unmodified. Bytes whose web bit is 1 are untouched; the block does no read-modify-write.
- cpu_stall is purely combinational from req/gnt. It is 0 whenever neither port requests.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] {RESP_NONE, RESP_IM, RESP_DM} resp_e
  - localparam WEB_READ = 4'b1111
  - localparam MEM_AW = 14, MEM_DW = 32
- One sub-module, arb_starve_counter: saturating CNT_W counter with inc/clr inputs and an at_limit output. It is reused by a future second-master (debug) port.
- Grant logic, SRAM mux and response FSM stay in the top module.

Test Plan:
1. IM-only fetch: im_req=1, im_addr=14'h0010, SRAM holds 32'h00A00093 at 0x10.
   - Cycle 0: im_gnt=1, mem_addr=0x0010, mem_web=4'b1111, cpu_stall=0.
   - Cycle 1: im_rvalid=1, im_rdata=32'h00A00093.
   - Afterwards, with im_req=0, im_rdata still reads 32'h00A00093.
2. Conflict, DM load wins: both req; dm_addr=0x0200, dm_web=4'b1111.
   - dm_gnt=1, im_gnt=0, cpu_stall=1.
   - Next cycle: dm_rvalid=1, im_rvalid=0.
3. Starvation, STARVE_LIMIT=3: both requests held high for 5 cycles.
   - Grants are DM, DM, DM, IM, DM; cpu_stall=1 in all 5 cycles.
   - Counter sequence is 0,1,2,3,0.
4. Byte store: dm_req=1, dm_web=4'b1101, dm_addr=0x0300, dm_wdata=32'h0000AB00.
   - mem_web=4'b1101, mem_datain=32'h0000AB00.
   - dm_rvalid stays 0 next cycle.
   - A subsequent read of 0x0300 returns byte 1 = 8'hAB, other bytes unchanged.
5. Back-to-back: IM read at cycle 0, DM read at cycle 1 (IM request dropped).
   - im_rvalid at cycle 1 and dm_rvalid at cycle 2, each with correct data.
   - No bubble cycles.
6. Reset mid-read: IM granted at cycle 0, then rst=0 asynchronously during cycle 1.
   - im_rvalid=0 and im_rdata=0 immediately; mem_cs=0, mem_web=4'b1111.
   - After rst returns to 1: no spurious rvalid and counter=0.
